// File: rtl/sd_pkg.sv
// sd_pkg: shared state encoding, sector size and counter widths for the SD sector arbiter
package sd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_RD, S_WR, S_GAP} state_t;
  localparam int SECTOR_BYTES = 512;
  localparam int CNT_W = 10;
  function automatic int tmo_w(input int cyc);
    return $clog2(cyc + 1);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, nearest requester after last wins
module rr_pick #(
  parameter int N = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic          valid
);
  // scan from farthest to nearest so the nearest pending index is written last
  always_comb begin
    gnt = '0;
    valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        gnt = '0;
        gnt[(int'(last) + k) % N] = 1'b1;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sd_sec_arbiter.sv
// sd_sec_arbiter: round-robin sharing of one SD sector engine between NREQ requesters
module sd_sec_arbiter #(
  parameter int NREQ = 2,
  parameter int SECTOR_BYTES = sd_pkg::SECTOR_BYTES,
  parameter int TIMEOUT_CYC = 25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_write,
  input  logic [32*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] wr_data,
  output logic [NREQ-1:0]   wr_req,
  output logic [7:0]        rd_data,
  output logic [NREQ-1:0]   rd_valid,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic              busy,
  output logic [NREQ-1:0]   grant,
  input  logic              sd_init_done,
  output logic              sd_sec_read,
  output logic              sd_sec_write,
  output logic [31:0]       sd_sec_read_addr,
  output logic [31:0]       sd_sec_write_addr,
  input  logic [7:0]        sd_sec_read_data,
  input  logic              sd_sec_read_data_valid,
  input  logic              sd_sec_read_end,
  output logic [7:0]        sd_sec_write_data,
  input  logic              sd_sec_write_data_req,
  input  logic              sd_sec_write_end
);
  import sd_pkg::*;
  localparam int IW = $clog2(NREQ);
  localparam int TW = tmo_w(TIMEOUT_CYC);
  state_t state, state_nx;
  logic [IW-1:0] last, gidx, pick_idx;
  logic [NREQ-1:0] pick;
  logic pick_ok, xfer, beat, fin_end, fin_abort;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [TW-1:0] tcnt;
  logic [31:0] addr;
  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req(req_valid & {NREQ{sd_init_done}}),
    .last(last),
    .gnt(pick),
    .valid(pick_ok)
  );
  // one-hot pick to index for slicing the address and data buses
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) if (pick[i]) pick_idx = IW'(i);
  end
  // transfer events, saturating byte count and next state
  always_comb begin
    xfer = state == S_RD || state == S_WR;
    beat = (state == S_RD && sd_sec_read_data_valid) || (state == S_WR && sd_sec_write_data_req);
    fin_end = (state == S_RD && sd_sec_read_end) || (state == S_WR && sd_sec_write_end);
    fin_abort = xfer && (tcnt == TW'(TIMEOUT_CYC - 1) || !sd_init_done);
    cnt_nx = (beat && cnt != CNT_W'(SECTOR_BYTES + 1)) ? cnt + 1'b1 : cnt;
    state_nx = state == S_IDLE  ? (pick_ok ? S_GRANT : S_IDLE) :
               state == S_GRANT ? (req_write[gidx] ? S_WR : S_RD) :
               state == S_GAP   ? S_IDLE :
               (fin_end || fin_abort) ? S_GAP : state;
  end
  // state, ownership, address latch, counters and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      last <= IW'(NREQ - 1);
      gidx <= '0;
      grant <= '0;
      addr <= '0;
      cnt <= '0;
      tcnt <= '0;
      done <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      done <= '0;
      err <= 1'b0;
      if (state == S_IDLE && pick_ok) begin
        gidx <= pick_idx;
        grant <= pick;
      end
      if (state == S_GRANT) begin
        addr <= req_addr[32*gidx +: 32];
        cnt <= '0;
        tcnt <= '0;
      end
      if (xfer) begin
        cnt <= cnt_nx;
        tcnt <= tcnt + 1'b1;
        if (fin_end || fin_abort) begin
          done <= grant;
          err <= fin_end ? cnt_nx != CNT_W'(SECTOR_BYTES) : 1'b1;
          last <= gidx;
          grant <= '0;
        end
      end
    end
  end
  // strobes follow state so reset drops them at once; data paths gated by ownership
  always_comb begin
    sd_sec_read = state == S_RD;
    sd_sec_write = state == S_WR;
    sd_sec_read_addr = addr;
    sd_sec_write_addr = addr;
    busy = state == S_GRANT || xfer;
    req_ready = state == S_GRANT ? grant : '0;
    rd_valid = (state == S_RD && sd_sec_read_data_valid) ? grant : '0;
    wr_req = (state == S_WR && sd_sec_write_data_req) ? grant : '0;
    rd_data = state == S_RD ? sd_sec_read_data : 8'h00;
    sd_sec_write_data = grant != '0 ? wr_data[8*gidx +: 8] : 8'h00;
  end
endmodule

// File: doc/sd_sec_arbiter.md
# sd_sec_arbiter

Round-robin controller that shares one SD-card SPI sector engine (`sd_card_top`) between NREQ independent requesters, e.g. a frame-dump writer and a configuration reader. Each requester issues a whole-sector read or write with a valid/ready handshake. The arbiter then sequences the engine's level-held `sd_sec_read`/`sd_sec_write` strobes, routes byte data and strobes to the granted requester, counts bytes, and reports completion, short transfers and timeouts.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..4)
- SECTOR_BYTES, 512, expected bytes per sector transfer
- TIMEOUT_CYC, 25_000_000, max cycles from strobe assertion to `*_end` (0.5 s at 50 MHz)

Ports:
- clk  in  1  system clock (50 MHz); single clock domain
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  request pending, held until accepted
- req_write  in  NREQ  1 = sector write, 0 = sector read
- req_addr  in  32*NREQ  sector address, slice i = [32*i+:32]
- req_ready  out  NREQ  one-cycle accept pulse
- wr_data  in  8*NREQ  write byte from requester i
- wr_req  out  NREQ  routed `sd_sec_write_data_req`
- rd_data  out  8  routed `sd_sec_read_data` (shared bus)
- rd_valid  out  NREQ  routed `sd_sec_read_data_valid`
- done  out  NREQ  one-cycle completion pulse
- err  out  1  valid with any `done`: 1 = timeout, init loss or byte count != SECTOR_BYTES
- busy  out  1  transfer in progress
- grant  out  NREQ  one-hot owner, 0 when idle
- sd_init_done  in  1  from engine
- sd_sec_read, sd_sec_write  out  1  level strobes to engine
- sd_sec_read_addr, sd_sec_write_addr  out  32  latched address
- sd_sec_read_data  in  8
- sd_sec_read_data_valid, sd_sec_read_end  in  1
- sd_sec_write_data  out  8  = wr_data slice of the granted requester (combinational mux)
- sd_sec_write_data_req, sd_sec_write_end  in  1

## Operation
- The states are IDLE, GRANT, RD, WR and GAP.
- IDLE: wait for `sd_init_done` = 1 and any `req_valid`. Pick the lowest index at or after `last+1` (mod NREQ), then go to GRANT.
- GRANT (1 cycle):
  - Pulse `req_ready[g]`.
  - Latch the address into both `*_addr` outputs.
  - Latch `req_write[g]`, clear the byte counter and the timeout counter.
  - Go to RD or WR.
- RD / WR:
  - Hold the matching strobe high. Route valid/req to index g only; other indices read 0.
  - Increment the byte counter on each `sd_sec_read_data_valid` or `sd_sec_write_data_req`. The counter saturates at SECTOR_BYTES+1.
  - On `*_end`: drop the strobe, pulse `done[g]`, and set `err` = (count != SECTOR_BYTES). Set `last` = g and go to GAP.
  - Timeout counter reaches TIMEOUT_CYC: drop the strobe, pulse `done[g]` with `err` = 1, go to GAP.
  - `sd_init_done` falls: same as timeout (abort, `err` = 1).
- GAP (1 cycle, strobes low): the engine sees a deassert before the next command. Go to IDLE.
- The opposite-direction `*_end` and stray valid/req in RD/WR are ignored and not counted.
- `req_valid` dropping after acceptance has no effect. A requester may re-request in the cycle after `done`.

## Timing
- Reset values: all outputs 0, `last` = NREQ-1 (so index 0 wins first), state IDLE.
- Latency:
  - `req_valid` seen in IDLE → `req_ready` pulses 1 cycle later (GRANT) → strobe high 2 cycles after the request.
  - `*_end` → strobe low and `done` on the next edge (registered).
  - Back-to-back: minimum 3 cycles of strobe low between transfers (GAP, IDLE, GRANT).
- `rd_data`, `rd_valid` and `wr_req` are combinational pass-throughs gated by `grant`, so they add zero latency.
- Simultaneous requests: strict round-robin. Each requester waits at most NREQ-1 transfers.
- `*_end` and timeout in the same cycle: the end wins, and `err` depends only on the count.
- `rst` mid-transfer: strobes drop asynchronously and no `done` is issued.

## Structure
- A shared package `sd_pkg` holds:
  - the state encoding constants
  - SECTOR_BYTES
  - the byte-counter width (10 bits)
  - the timeout-counter width ($clog2(TIMEOUT_CYC+1))
- One sub-module, `rr_pick`: combinational round-robin selector with inputs (req vector, last index) and outputs (one-hot grant, valid).
- Everything else stays in a single FSM plus counters in `sd_sec_arbiter`.

## Test plan
- Single read, req 0, addr 0x10: engine model streams 512 valid bytes then `end` → `sd_sec_read_addr` = 0x10, `rd_valid[0]` 512 times, `rd_valid[1]` never, `done[0]` = 1, `err` = 0.
- Req 0 and req 1 both asserted in the same cycle after reset → grant 0 first, then 1. Repeat both → 0 then 1 again. Strobe low for ≥ 3 cycles between transfers.
- Write from req 1 with `wr_data[15:8]` = counter: engine captures 512 bytes matching, `wr_req[0]` stays 0, `done[1]`, `err` = 0.
- Engine ends a read after 511 bytes → `done` with `err` = 1. The next request is still served normally.
- Engine never asserts `end`, TIMEOUT_CYC = 1000 → strobe drops at cycle 1000 after assertion, `done` + `err` = 1. Then drop `sd_init_done` during the next transfer → immediate abort with `err` = 1, and no grants while init is low.
- Assert `rst` mid-write → all outputs 0 asynchronously, no `done`. After release, req 0 is granted first.
